quad_cost_eval: RTL
===================

QUAD_COST_EVAL -- requirements
Module: quad_cost_eval

Interface
REQ-001 Parameter N_VARS, default 4: number of input variables (channels), range 1..16.
REQ-002 Parameter IN_W, default 16: width of each signed input, offset and weight.
REQ-003 Parameter FRAC, default 8: fractional bits shared by all fixed-point operands (Q(IN_W-FRAC).FRAC inputs).
REQ-004 Parameter ACC_W, default 32: width of internal datapath and result (Q(ACC_W-FRAC).FRAC).
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: request one evaluation; sampled only in IDLE.
REQ-008 Port clear, input, 1: synchronous abort of an evaluation in progress.
REQ-009 Port x_in, input, N_VARS*IN_W: packed signed variables; channel i at bits [i*IN_W +: IN_W].
REQ-010 Port offset_in, input, N_VARS*IN_W: packed signed per-channel offsets c_i, same packing.
REQ-011 Port weight_in, input, N_VARS*IN_W: packed signed per-channel weights w_i, same packing.
REQ-012 Port bias_in, input, ACC_W: signed constant term.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse when z_out is valid.
REQ-015 Port z_out, output, ACC_W: signed result, held until the next completed evaluation.
REQ-016 Port overflow, output, 1: any saturation occurred in the last completed evaluation.

Function
REQ-017 Computes z = bias + sum over i of w_i*(x_i - c_i)^2, all in fixed point with FRAC fractional bits.
REQ-018 FSM states: IDLE, LOAD, DIFF, SQR, WGT, ACC, DONE; channel index counter idx runs 0..N_VARS-1.
REQ-019 IDLE->LOAD when start=1; otherwise stay in IDLE.
REQ-020 LOAD: capture x_in, offset_in, weight_in and bias_in into registers; acc <= sign-extended bias; idx <= 0; clear the internal overflow flag; next state DIFF.
REQ-021 DIFF: d <= sext(x_idx) - sext(c_idx) at ACC_W; cannot overflow for IN_W < ACC_W.
REQ-022 SQR: s <= (d*d) >>> FRAC, saturated to ACC_W signed range.
REQ-023 WGT: t <= (sext(w_idx)*s) >>> FRAC, saturated to ACC_W signed range.
REQ-024 ACC: acc <= acc + t, saturated to ACC_W signed range; go to DIFF with idx+1 if idx < N_VARS-1, else to DONE.
REQ-025 Rounding: arithmetic right shift of the full-width product (round toward negative infinity); no other rounding.
REQ-026 Any saturation in SQR, WGT or ACC sets the internal overflow flag; the flag stays set until the next LOAD.
REQ-027 On the edge entering DONE: z_out <= acc and overflow <= internal flag.
REQ-028 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-029 Latency: done is high after the (4*N_VARS+1)th rising edge following the edge that sampled start (17 edges for N_VARS=4).
REQ-030 start is ignored while busy=1, including during DONE; no queueing.
REQ-031 clear=1 in any state except IDLE: next state IDLE, no done pulse, z_out and overflow unchanged; clear has priority over every other transition.
REQ-032 Inputs may change freely after LOAD without affecting the evaluation in progress.

Reset
REQ-033 rst_n low: state=IDLE, idx=0, all data registers=0, z_out=0, done=0, overflow=0, busy=0, applied immediately regardless of clk.
REQ-034 Reset asserted mid-evaluation aborts it with no done pulse; the first evaluation after reset behaves identically to any later one.

Structure
REQ-035 Package quad_eval_pkg holds the state enumeration, the signed saturation-limit constants derived from ACC_W, and a saturate function.
REQ-036 Sub-module fixed_sat_mult (parameters ACC_W, FRAC; signed ACC_W x ACC_W multiply, arithmetic shift by FRAC, saturation, sat flag) is instantiated once and shared by SQR and WGT via an operand mux.
REQ-037 Only one multiplier and one adder in the datapath.

Verification (N_VARS=4, Q8.8, ACC_W=32; offsets (2,0,-2,0)=0x0200,0x0000,0xFE00,0x0000; weights (1,1,1,25)=0x0100 x3,0x1900; bias -5=0xFFFFFB00)
REQ-038 x=(0,0,0,0), pulse start -> done after 17 edges, z_out=0x00000300, overflow=0.
REQ-039 x=(3,1,-1,1) -> z_out=0x00001700 (23.0), overflow=0.
REQ-040 x=(2.5,0,-2,0), bias 0, weights all 0x0100 -> z_out=0x00000040 (0.25).
REQ-041 x all 0x7F00, offsets all 0x8000, weights all 0x7F00 -> z_out=0x7FFFFFFF, overflow=1; next evaluation with REQ-038 stimulus -> overflow=0.
REQ-042 start re-pulsed at edge 5 of an evaluation -> single done, result unchanged; clear at edge 8 -> busy=0 next cycle, no done, z_out keeps its prior value.
REQ-043 rst_n pulsed low mid-evaluation -> z_out=0, busy=0, done never asserted; a following start gives the REQ-038 result.

Source files
------------

// File: rtl/quad_eval_pkg.sv
// Shared definitions for the quadratic cost evaluator: FSM state encoding,
// signed saturation limits and the saturate helper used by every clipping point.
package quad_eval_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int FRAC_DEF   = 8;

  // Every clipped value is carried at this width, so one helper serves any
  // ACC_W up to 64 (a full ACC_W x ACC_W product).
  localparam int WIDE_W     = 128;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_DIFF = 3'd2;
  localparam state_t ST_SQR  = 3'd3;
  localparam state_t ST_WGT  = 3'd4;
  localparam state_t ST_ACC  = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  localparam logic signed [WIDE_W-1:0] WIDE_ONE = WIDE_W'(1);

  function automatic logic signed [WIDE_W-1:0] sat_max(input int w);
    return (WIDE_ONE <<< (w - 1)) - WIDE_ONE;
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  function automatic logic signed [WIDE_W-1:0] saturate(
    input  logic signed [WIDE_W-1:0] v,
    input  int                       w,
    output logic                     sat
  );
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi  = sat_max(w);
    lo  = sat_min(w);
    sat = 1'b0;
    if (v > hi) begin
      sat = 1'b1;
      return hi;
    end
    if (v < lo) begin
      sat = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fixed_sat_mult.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC
// (round toward negative infinity), then clip to the ACC_W signed range.
module fixed_sat_mult
  import quad_eval_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] p,
  output logic                    sat
);

  logic signed [2*ACC_W-1:0]  prod;
  logic signed [2*ACC_W-1:0]  shifted;
  logic signed [WIDE_W-1:0]   clipped;
  logic                       unused_hi;

  assign prod    = a * b;
  assign shifted = prod >>> FRAC;

  always_comb begin
    clipped = saturate(WIDE_W'(shifted), ACC_W, sat);
  end

  assign p         = clipped[ACC_W-1:0];
  assign unused_hi = ^clipped[WIDE_W-1:ACC_W];

endmodule

// File: rtl/quad_cost_eval.sv
// Sequential evaluator of z = bias + sum_i w_i*(x_i - c_i)^2 in fixed point,
// one channel per four cycles over a single shared multiplier and adder.
module quad_cost_eval
  import quad_eval_pkg::*;
#(
  parameter int N_VARS = 4,
  parameter int IN_W   = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic [N_VARS*IN_W-1:0]   x_in,
  input  logic [N_VARS*IN_W-1:0]   offset_in,
  input  logic [N_VARS*IN_W-1:0]   weight_in,
  input  logic [ACC_W-1:0]         bias_in,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-1:0]         z_out,
  output logic                     overflow
);

  localparam int BUS_W = N_VARS * IN_W;
  localparam int IDX_W = (N_VARS > 1) ? $clog2(N_VARS) : 1;

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]         idx;
  logic [BUS_W-1:0]         x_r;
  logic [BUS_W-1:0]         c_r;
  logic [BUS_W-1:0]         w_r;
  logic signed [ACC_W-1:0]  d_r;
  logic signed [ACC_W-1:0]  s_r;
  logic signed [ACC_W-1:0]  t_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     ovf_r;

  logic                     last_ch;
  logic                     abort;

  logic signed [IN_W-1:0]   x_sel;
  logic signed [IN_W-1:0]   c_sel;
  logic signed [IN_W-1:0]   w_sel;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  c_ext;
  logic signed [ACC_W-1:0]  w_ext;

  logic signed [ACC_W-1:0]  mul_a;
  logic signed [ACC_W-1:0]  mul_b;
  logic signed [ACC_W-1:0]  mul_p;
  logic                     mul_sat;

  logic [ACC_W-1:0]         add_a;
  logic [ACC_W-1:0]         add_b;
  logic                     add_cin;
  logic [ACC_W:0]           add_sum;
  logic signed [WIDE_W-1:0] add_wide;
  logic signed [ACC_W-1:0]  add_res;
  logic                     add_sat;
  logic                     unused_add_hi;

  assign x_sel = x_r[idx*IN_W +: IN_W];
  assign c_sel = c_r[idx*IN_W +: IN_W];
  assign w_sel = w_r[idx*IN_W +: IN_W];
  assign x_ext = ACC_W'(x_sel);
  assign c_ext = ACC_W'(c_sel);
  assign w_ext = ACC_W'(w_sel);

  assign last_ch = (idx == IDX_W'(N_VARS - 1));
  assign abort   = clear && (state != ST_IDLE);

  // SQR squares d; WGT scales the square by the channel weight.
  assign mul_a = (state == ST_WGT) ? w_ext : d_r;
  assign mul_b = (state == ST_WGT) ? s_r   : d_r;

  fixed_sat_mult #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_mult (
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .sat (mul_sat)
  );

  // The single adder subtracts in DIFF (a + ~b + 1) and accumulates in ACC;
  // one guard bit lets the saturate helper see the true sum.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    add_a   = acc_r;
    add_b   = t_r;
    add_cin = 1'b0;
    if (state == ST_DIFF) begin
      add_a   = x_ext;
      add_b   = ~c_ext;
      add_cin = 1'b1;
    end
    add_sum  = {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b}
             + {{ACC_W{1'b0}}, add_cin};
    add_wide = saturate(WIDE_W'($signed(add_sum)), ACC_W, add_sat);
  end

  assign add_res       = add_wide[ACC_W-1:0];
  assign unused_add_hi = ^add_wide[WIDE_W-1:ACC_W];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_DIFF;
      ST_DIFF: state_nxt = ST_SQR;
      ST_SQR:  state_nxt = ST_WGT;
      ST_WGT:  state_nxt = ST_ACC;
      ST_ACC:  state_nxt = last_ch ? ST_DONE : ST_DIFF;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are plain flops, not a RAM, so they are cleared with the rest of the state.
      state    <= ST_IDLE;
      idx      <= '0;
      x_r      <= '0;
      c_r      <= '0;
      w_r      <= '0;
      d_r      <= '0;
      s_r      <= '0;
      t_r      <= '0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
      z_out    <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state <= state_nxt;
      if (!abort) begin
        case (state)
          ST_LOAD: begin
            x_r   <= x_in;
            c_r   <= offset_in;
            w_r   <= weight_in;
            acc_r <= bias_in;
            idx   <= '0;
            ovf_r <= 1'b0;
          end
          ST_DIFF: d_r <= add_res;
          ST_SQR: begin
            s_r <= mul_p;
            if (mul_sat) ovf_r <= 1'b1;
          end
          ST_WGT: begin
            t_r <= mul_p;
            if (mul_sat) ovf_r <= 1'b1;
          end
          ST_ACC: begin
            acc_r <= add_res;
            ovf_r <= ovf_r | add_sat;
            if (last_ch) begin
              // The final accumulation lands in z_out on the same edge that enters DONE.
              z_out    <= add_res;
              overflow <= ovf_r | add_sat;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
